port_io_device: RTL and testbench

Peripheral on the far side of the processor's 8-bit IN/OUT port. It buffers bytes the processor emits with OUT into a TX FIFO for a host-side consumer. It buffers host-supplied bytes in an RX FIFO that the processor drains with IN. It raises a one-cycle `intr_signal` pulse toward the processor when fresh input arrives. It replaces bench-driven `in_port`/`intr_signal` stimulus at system level.

---
 rtl/port_io_pkg.sv | 20 ++
 rtl/port_io_fifo.sv | 51 +++++
 rtl/port_io_device.sv | 116 +++++++++++
 tb/tb_port_io_device.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/port_io_pkg.sv
// Shared constants and types for the processor-side port I/O peripheral.
package port_io_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ST_W   = 4;

    // Bit positions inside the status word {tx_ovf, rx_unf, tx_full, rx_empty}
    localparam int unsigned ST_RX_EMPTY = 0;
    localparam int unsigned ST_TX_FULL  = 1;
    localparam int unsigned ST_RX_UNF   = 2;
    localparam int unsigned ST_TX_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PULSE      = 2'd1,
        ARMED_WAIT = 2'd2
    } intr_state_t;

endpackage

// File: rtl/port_io_fifo.sv
// Synchronous FIFO with 1-cycle latency; a push is still accepted when full
// provided a pop happens on the same edge.
module port_io_fifo #(
    parameter int unsigned DATA_W = port_io_pkg::DATA_W,
    parameter int unsigned DEPTH  = port_io_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == CNT_W'(0));
    assign o_head  = r_mem[r_rd_ptr];

    // Full/empty come from registered state, so a pop frees the slot a same-edge push fills
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/port_io_device.sv
// Port I/O peripheral: TX FIFO for processor OUT, RX FIFO for processor IN,
// sticky error flags and an optional interrupt FSM (enabled by PORT_IO_INTR_EN).
module port_io_device #(
    parameter int unsigned DATA_W = port_io_pkg::DATA_W,
    parameter int unsigned DEPTH  = port_io_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_out_we,
    output logic [DATA_W-1:0] cpu_in_data,
    input  logic              cpu_in_re,
    output logic              intr_signal,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              host_rd_valid,
    input  logic              host_rd_ready,
    output logic [3:0]        status
);

    import port_io_pkg::*;

    logic              w_rx_full;
    logic              w_rx_empty;
    logic [DATA_W-1:0] w_rx_head;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [DATA_W-1:0] w_tx_head;
    logic              r_tx_ovf;
    logic              r_rx_unf;

    port_io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (host_wr_valid),
        .i_data  (host_wr_data),
        .i_pop   (cpu_in_re),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head)
    );

    port_io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cpu_out_we),
        .i_data  (cpu_out_data),
        .i_pop   (host_rd_ready),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head)
    );

    // A full TX FIFO only drops the byte if the host is not draining on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_ovf <= 1'b0;
            r_rx_unf <= 1'b0;
        end else begin
            r_tx_ovf <= r_tx_ovf | (cpu_out_we & w_tx_full & ~host_rd_ready);
            r_rx_unf <= r_rx_unf | (cpu_in_re & w_rx_empty);
        end
    end

    assign cpu_in_data   = w_rx_empty ? '0 : w_rx_head;
    assign host_rd_data  = w_tx_empty ? '0 : w_tx_head;
    assign host_wr_ready = ~w_rx_full;
    assign host_rd_valid = ~w_tx_empty;

    assign status[ST_TX_OVF]   = r_tx_ovf;
    assign status[ST_RX_UNF]   = r_rx_unf;
    assign status[ST_TX_FULL]  = w_tx_full;
    assign status[ST_RX_EMPTY] = w_rx_empty;

`ifdef PORT_IO_INTR_EN
    intr_state_t r_state;
    logic        r_intr;

    // One pulse per burst: re-armed only after the RX FIFO has drained
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_intr  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_intr <= 1'b0;
                    if (host_wr_valid & w_rx_empty) begin
                        r_state <= PULSE;
                        r_intr  <= 1'b1;
                    end
                end
                PULSE: begin
                    r_state <= ARMED_WAIT;
                    r_intr  <= 1'b0;
                end
                ARMED_WAIT: begin
                    r_intr <= 1'b0;
                    if (w_rx_empty) r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_intr  <= 1'b0;
                end
            endcase
        end
    end

    assign intr_signal = r_intr;
`else
    assign intr_signal = 1'b0;
`endif

endmodule

// File: tb/tb_port_io_device.sv
// Bench for port_io_device: directed scenarios then randomized traffic, all
// checked against a queue-based reference model.
module tb_port_io_device;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] cpu_out_data;
    logic          cpu_out_we;
    logic [DW-1:0] cpu_in_data;
    logic          cpu_in_re;
    logic          intr_signal;
    logic [DW-1:0] host_wr_data;
    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [DW-1:0] host_rd_data;
    logic          host_rd_valid;
    logic          host_rd_ready;
    logic [3:0]    status;

    always #5 clk = ~clk;

    port_io_device #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_out_data  (cpu_out_data),
        .cpu_out_we    (cpu_out_we),
        .cpu_in_data   (cpu_in_data),
        .cpu_in_re     (cpu_in_re),
        .intr_signal   (intr_signal),
        .host_wr_data  (host_wr_data),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_rd_data  (host_rd_data),
        .host_rd_valid (host_rd_valid),
        .host_rd_ready (host_rd_ready),
        .status        (status)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: byte queues, sticky flags, and interrupt phase
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] txq[$];
    bit m_ovf, m_unf, m_pulse, m_armed;

    task automatic model_edge();
        int  rxn;
        int  txn;
        bit  rx_pop;
        bit  rx_push;
        bit  tx_pop;
        bit  tx_push;
        if (rst) begin
            rxq.delete();
            txq.delete();
            m_ovf = 0; m_unf = 0; m_pulse = 0; m_armed = 0;
            return;
        end
        rxn     = rxq.size();
        txn     = txq.size();
        rx_pop  = cpu_in_re && rxn > 0;
        rx_push = host_wr_valid && (rxn < DEPTH || rx_pop);
        tx_pop  = host_rd_ready && txn > 0;
        tx_push = cpu_out_we && (txn < DEPTH || tx_pop);
        if (cpu_in_re && rxn == 0) m_unf = 1;
        if (cpu_out_we && !tx_push) m_ovf = 1;
        if (m_pulse) begin
            m_pulse = 0;
            m_armed = 1;
        end else if (m_armed) begin
            if (rxn == 0) m_armed = 0;
        end else if (rx_push && rxn == 0) begin
            m_pulse = 1;
        end
        if (rx_pop)  void'(rxq.pop_front());
        if (rx_push) rxq.push_back(host_wr_data);
        if (tx_pop)  void'(txq.pop_front());
        if (tx_push) txq.push_back(cpu_out_data);
    endtask

    task automatic check_all();
        logic [DW-1:0] e_in;
        logic [DW-1:0] e_rd;
        logic          e_intr;
        e_in = (rxq.size() > 0) ? rxq[0] : '0;
        e_rd = (txq.size() > 0) ? txq[0] : '0;
`ifdef PORT_IO_INTR_EN
        e_intr = m_pulse;
`else
        e_intr = 1'b0;
`endif
        check("cpu_in_data",   32'(cpu_in_data),   32'(e_in));
        check("intr_signal",   32'(intr_signal),   32'(e_intr));
        check("host_wr_ready", 32'(host_wr_ready), 32'(rxq.size() < DEPTH));
        check("host_rd_valid", 32'(host_rd_valid), 32'(txq.size() > 0));
        check("host_rd_data",  32'(host_rd_data),  32'(e_rd));
        check("status",        32'(status),
              32'({m_ovf, m_unf, txq.size() == DEPTH, rxq.size() == 0}));
    endtask

    // Apply one cycle of inputs, advance the model at the edge, check #1 later
    task automatic step(input bit r, input logic [DW-1:0] wd, input bit wv, input bit re,
                        input logic [DW-1:0] od, input bit we, input bit rr);
        rst           = r;
        host_wr_data  = wd;
        host_wr_valid = wv;
        cpu_in_re     = re;
        cpu_out_data  = od;
        cpu_out_we    = we;
        host_rd_ready = rr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic host_write(input logic [DW-1:0] d);
        step(0, d, 1, 0, 8'h00, 0, 0);
    endtask

    task automatic cpu_read();
        step(0, 8'h00, 0, 1, 8'h00, 0, 0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pw;
        int pr;
        int po;
        int ph;
        step(1, 8'h00, 0, 0, 8'h00, 0, 0);
        step(1, 8'h00, 0, 0, 8'h00, 0, 0);
        check("rst_status", 32'(status), 32'h1);
        check("rst_in_data", 32'(cpu_in_data), 32'h0);
        check("rst_wr_ready", 32'(host_wr_ready), 32'h1);

        // Single byte into empty RX, then read and underflow
        host_write(8'h03);
        check("rx_03", 32'(cpu_in_data), 32'h03);
`ifdef PORT_IO_INTR_EN
        check("intr_first", 32'(intr_signal), 32'h1);
`endif
        idle();
        check("intr_drop", 32'(intr_signal), 32'h0);
        cpu_read();
        cpu_read();
        check("rx_unf", 32'(status[2]), 32'h1);

        // Burst of three: one pulse, in-order reads, then a new pulse after drain
        host_write(8'h0A);
        host_write(8'h20);
        host_write(8'h0F);
        check("burst_head", 32'(cpu_in_data), 32'h0A);
        cpu_read();
        cpu_read();
        check("burst_last", 32'(cpu_in_data), 32'h0F);
        cpu_read();
        idle();
        host_write(8'h77);
        cpu_read();

        // TX overflow with host stalled, then host drains in order
        foreach (txq[i]) ; // queue starts empty here
        step(0, 8'h00, 0, 0, 8'hAA, 1, 0);
        step(0, 8'h00, 0, 0, 8'hBB, 1, 0);
        step(0, 8'h00, 0, 0, 8'hCC, 1, 0);
        step(0, 8'h00, 0, 0, 8'hDD, 1, 0);
        step(0, 8'h00, 0, 0, 8'hEE, 1, 0);
        check("tx_ovf_full", 32'(status[3:1]), 32'b111);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 8'h00, 0, 1);
        check("tx_drained", 32'(host_rd_valid), 32'h0);

        // Full RX with simultaneous write and read keeps occupancy at DEPTH
        for (int i = 0; i < 4; i++) host_write(8'(8'h11 * (i + 1)));
        step(0, 8'h55, 1, 1, 8'h00, 0, 0);
        check("rx_full_head", 32'(cpu_in_data), 32'h22);
        check("rx_still_full", 32'(host_wr_ready), 32'h0);
        for (int i = 0; i < 4; i++) cpu_read();
        idle();

        // Reset with both FIFOs half full and the interrupt waiting for drain
        host_write(8'h31);
        host_write(8'h32);
        step(0, 8'h00, 0, 0, 8'h41, 1, 0);
        step(0, 8'h00, 0, 0, 8'h42, 1, 0);
        step(1, 8'h00, 0, 0, 8'h00, 0, 0);
        check("rst_mid_status", 32'(status), 32'h1);
        host_write(8'h99);
`ifdef PORT_IO_INTR_EN
        check("intr_after_rst", 32'(intr_signal), 32'h1);
`endif

        // Randomized traffic with activity levels varying per block
        for (int blk = 0; blk < 6; blk++) begin
            pw = int'($urandom_range(10, 90));
            pr = int'($urandom_range(10, 90));
            po = int'($urandom_range(10, 90));
            ph = int'($urandom_range(10, 90));
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(0, 249) == 0,
                     8'($urandom),
                     int'($urandom_range(0, 99)) < pw,
                     int'($urandom_range(0, 99)) < pr,
                     8'($urandom),
                     int'($urandom_range(0, 99)) < po,
                     int'($urandom_range(0, 99)) < ph);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
